fpga1_transmitter: RTL and testbench

FPGA1_TRANSMITTER -- requirements
Module: fpga1_transmitter

---
 rtl/fpga1_transmitter.sv | 98 +++++++++
 tb/tb_fpga1_transmitter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fpga1_transmitter.sv
// fpga1_transmitter: 4-phase req/ack word transmitter to a peer FPGA with synchronized handshake inputs.
// Defining FPGA1_TX_TIMEOUT_EN adds a handshake-stall timeout of TIMEOUT_CYCLES clocks.
module fpga1_transmitter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_done,
    output logic        busy,
    output logic [31:0] data_out,
    output logic        req_out,
    input  logic        rdy_in,
    input  logic        ack_in,
    output logic        peer_rdy,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  ack_sync_q, rdy_sync_q;
    logic [31:0] data_q, data_d;
    logic        req_q, req_d;
    logic        ack_s, tout, aborted;

    assign ack_s    = ack_sync_q[1];
    assign peer_rdy = rdy_sync_q[1];
    assign tx_ready = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign data_out = data_q;
    assign req_out  = req_q;

`ifdef FPGA1_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;
    assign cnt_d   = (state_d == state_q && state_q != IDLE) ? cnt_q + 1'b1 : '0;
    assign tout    = state_q != IDLE && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    // a word abandoned in REQ must not report tx_done when the peer finally releases
    assign abort_d = state_d == IDLE ? 1'b0 : (state_q == REQ && timeout_err) ? 1'b1 : abort_q;
    assign aborted = abort_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end
`else
    assign tout    = 1'b0;
    assign aborted = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        req_d       = req_q;
        tx_done     = 1'b0;
        timeout_err = 1'b0;
        unique case (state_q)
            IDLE: if (tx_valid) begin
                data_d  = tx_data;
                req_d   = 1'b1;
                state_d = REQ;
            end
            REQ: if (ack_s || tout) begin
                timeout_err = !ack_s;
                req_d       = 1'b0;
                state_d     = RELEASE;
            end
            RELEASE: if (!ack_s || tout) begin
                tx_done     = !ack_s && !aborted;
                timeout_err = ack_s;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            req_q      <= 1'b0;
            ack_sync_q <= '0;
            rdy_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            req_q      <= req_d;
            ack_sync_q <= {ack_sync_q[0], ack_in};
            rdy_sync_q <= {rdy_sync_q[0], rdy_in};
        end
    end
endmodule

// File: tb/tb_fpga1_transmitter.sv
// tb_fpga1_transmitter: scoreboard bench; accepted words are queued in order and
// every tx_done / req_out cycle is checked against the head of the queue.
module tb_fpga1_transmitter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        rdy_in = 1'b0;
    logic        ack_in = 1'b0;
    logic        tx_ready, tx_done, busy, req_out, peer_rdy, timeout_err;
    logic [31:0] data_out;
    int          checks = 0, errors = 0, dones = 0, ack_dly = 3, rel_dly = 2;
    bit          peer_mute = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fpga1_transmitter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy), .data_out(data_out),
        .req_out(req_out), .rdy_in(rdy_in), .ack_in(ack_in), .peer_rdy(peer_rdy),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // peer FPGA: ack some cycles after req, release some cycles after req falls
    always begin
        @(posedge clk); #1;
        if (!peer_mute && req_out) begin
            repeat (ack_dly) @(posedge clk);
            #2 ack_in = 1'b1;
            for (int i = 0; i < 200 && req_out; i++) begin @(posedge clk); #1; end
            repeat (rel_dly) @(posedge clk);
            #2 ack_in = 1'b0;
        end
    end

    // monitor: pops the scoreboard on tx_done, checks data stability while req_out is high
    always @(negedge clk) if (rst_n) begin
        chk("busy_vs_ready", busy, !tx_ready);
        if (tx_ready) chk("idle_req_low", req_out, 0);
        if (tx_done) begin
            dones++;
            chk("done_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) chk("done_data", data_out, exp_q.pop_front());
        end else if (req_out) begin
            chk("req_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) chk("req_data", data_out, exp_q[0]);
        end
    end

    task automatic send(input logic [31:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                chk("no_overlap", exp_q.size(), 0);
                exp_q.push_back(w);
                @(posedge clk); #1;
                return;
            end
        end
        chk("accept_timeout", tx_ready, 1);
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 3000 && dones < n; i++) begin @(posedge clk); #1; end
        chk("done_count", dones, n);
        chk("ready_after_done", tx_ready, 1);
    endtask

    initial begin
        int n, lat, want;
        rdy_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", tx_ready, 1);
        chk("rst_req", req_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_peer_rdy", peer_rdy, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("peer_rdy_sync", peer_rdy, 1);

        send(32'hDEADBEEF);
        tx_valid = 1'b0;
        wait_done(1);
        repeat (5) @(posedge clk);
        #1 chk("single_once", dones, 1);

        send(32'h00000001);
        send(32'hFFFFFFFF);
        tx_valid = 1'b0;
        wait_done(3);

        rel_dly = 20;
        send(32'hA5A55A5A);
        tx_valid = 1'b0;
        for (int i = 0; i < 200 && !(ack_in && !req_out); i++) @(negedge clk);
        n = 0;
        while (ack_in && n < 100) begin
            @(negedge clk);
            if (ack_in) chk("held_ready", tx_ready, 0);
            n++;
        end
        chk("held_len", n >= 19 && n <= 22, 1);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            lat++;
            if (tx_done) break;
        end
        chk("held_latency", lat >= 2 && lat <= 3, 1);
        rel_dly = 2;
        wait_done(4);

        peer_mute = 1'b1;
        send(32'hCAFEF00D);
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mrst_req", req_out, 0);
        chk("mrst_data", data_out, 0);
        chk("mrst_ready", tx_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        rst_n = 1'b1;
        peer_mute = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("mrst_no_done", dones, 4);
        send(32'h12345678);
        tx_valid = 1'b0;
        wait_done(5);
        want = 5;

        peer_mute = 1'b1;
        send(32'h0BAD0BAD);
        tx_valid = 1'b0;
`ifdef FPGA1_TX_TIMEOUT_EN
        n = 1;
        while (!timeout_err && n < 100) begin @(posedge clk); #1; n++; end
        chk("tout_cycle", n, 16);
        chk("tout_no_done_pulse", tx_done, 0);
        @(posedge clk);
        #1 chk("tout_req_drop", req_out, 0);
        chk("tout_pulse_len", timeout_err, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (3) @(posedge clk);
        #1 chk("tout_idle", tx_ready, 1);
        chk("tout_no_done", dones, want);
        peer_mute = 1'b0;
`else
        n = 0;
        repeat (5000) begin
            @(posedge clk); #1;
            if (req_out && !timeout_err) n++;
        end
        chk("stall_hold", n, 5000);
        peer_mute = 1'b0;
        want++;
        wait_done(want);
`endif

        for (int k = 0; k < 40; k++) begin
            ack_dly = $urandom_range(0, 5);
            rel_dly = $urandom_range(0, 5);
            send($urandom);
            tx_valid = 1'b0;
            want++;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_done(want);
        repeat (10) @(posedge clk);
        #1 chk("final_dones", dones, want);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end
endmodule
